// File: rtl/load_store_unit.sv
// load_store_unit
// Converts byte-addressed RISC-V loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW)
// into word accesses on a single-ported, word-addressed data memory.
// Sub-word stores are done as read-modify-write. Misaligned, out-of-range
// and malformed requests respond with an error and never touch memory.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   reqValid/reqReady           request handshake (ready only in IDLE)
//   reqRead/reqWrite            load / store select (exactly one must be set)
//   funct3                      RISC-V width/sign code
//   reqAddress, reqWriteData    byte address, right-aligned store data
//   respValid                   one-cycle completion pulse
//   respLoadData, respError     extended load result / error flag
//   MemRead, MemWrite           data memory strobes (never both high)
//   address, writeData          word index and merged word to memory
//   readData                    combinational read data from memory
module load_store_unit #(
  parameter int unsigned DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqRead,
  input  logic        reqWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] reqAddress,
  input  logic [31:0] reqWriteData,
  output logic        respValid,
  output logic [31:0] respLoadData,
  output logic        respError,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] address,
  output logic [31:0] writeData,
  input  logic [31:0] readData
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  state_t      r_state, w_next;
  logic        r_write;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;
  logic [31:0] r_address;
  logic [31:0] r_write_data;
  logic [31:0] r_load_data;
  logic        r_error;

  logic        w_accept, w_is_load, w_is_store, w_f3_ok;
  logic        w_misalign, w_oor, w_error, w_full_word;
  logic [31:0] w_word_idx;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_ext, w_merged;

  // Request decode, evaluated against the live request in IDLE
  assign w_accept    = (r_state == S_IDLE) && reqValid;
  assign w_is_load   = reqRead && !reqWrite;
  assign w_is_store  = reqWrite && !reqRead;
  assign w_full_word = (funct3[1:0] == 2'b10);
  assign w_word_idx  = {2'b00, reqAddress[31:2]};

  always_comb begin
    w_f3_ok = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
      3'b100, 3'b101:         w_f3_ok = w_is_load;  // unsigned forms are load-only
      default:                w_f3_ok = 1'b0;
    endcase
  end

  assign w_misalign = ((funct3[1:0] == 2'b01) && reqAddress[0]) ||
                      (w_full_word && (reqAddress[1:0] != 2'b00));
  assign w_oor      = (w_word_idx >= DEPTH);
  assign w_error    = !(w_is_load || w_is_store) || !w_f3_ok || w_misalign || w_oor;

  // Lane extraction from the word currently being read
  always_comb begin
    w_byte = readData[7:0];
    case (r_lane)
      2'd0: w_byte = readData[7:0];
      2'd1: w_byte = readData[15:8];
      2'd2: w_byte = readData[23:16];
      2'd3: w_byte = readData[31:24];
      default: w_byte = readData[7:0];
    endcase
  end

  assign w_half = r_lane[1] ? readData[31:16] : readData[15:0];

  always_comb begin
    w_load_ext = readData;
    case (r_funct3)
      3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_ext = {24'h0, w_byte};
      3'b101:  w_load_ext = {16'h0, w_half};
      default: w_load_ext = readData;
    endcase
  end

  // Read-modify-write merge: replace only the addressed lane
  always_comb begin
    w_merged = readData;
    if (r_funct3[1:0] == 2'b00) begin
      case (r_lane)
        2'd0: w_merged[7:0]   = r_wdata[7:0];
        2'd1: w_merged[15:8]  = r_wdata[7:0];
        2'd2: w_merged[23:16] = r_wdata[7:0];
        2'd3: w_merged[31:24] = r_wdata[7:0];
        default: w_merged = readData;
      endcase
    end else if (r_lane[1]) begin
      w_merged[31:16] = r_wdata[15:0];
    end else begin
      w_merged[15:0] = r_wdata[15:0];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM next state and strobes
  always_comb begin
    w_next    = r_state;
    reqReady  = 1'b0;
    respValid = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    case (r_state)
      S_IDLE: begin
        reqReady = 1'b1;
        if (reqValid) begin
          if (w_error)                   w_next = S_RESP;
          else if (w_is_load)            w_next = S_READ;
          else if (w_full_word)          w_next = S_WRITE;
          else                           w_next = S_READ;
        end
      end
      S_READ: begin
        MemRead = 1'b1;
        w_next  = r_write ? S_WRITE : S_RESP;
      end
      S_WRITE: begin
        MemWrite = 1'b1;
        w_next   = S_RESP;
      end
      S_RESP: begin
        respValid = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request latches and datapath registers. address/writeData only change
  // when a memory access is actually going to use them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write      <= 1'b0;
      r_funct3     <= '0;
      r_lane       <= '0;
      r_wdata      <= '0;
      r_address    <= '0;
      r_write_data <= '0;
      r_load_data  <= '0;
      r_error      <= 1'b0;
    end else if (w_accept) begin
      r_write     <= w_is_store;
      r_funct3    <= funct3;
      r_lane      <= reqAddress[1:0];
      r_wdata     <= reqWriteData;
      r_error     <= w_error;
      r_load_data <= '0;
      if (!w_error) begin
        r_address <= w_word_idx;
        if (w_is_store && w_full_word) r_write_data <= reqWriteData;
      end
    end else if (r_state == S_READ) begin
      if (r_write) r_write_data <= w_merged;
      else         r_load_data  <= w_load_ext;
    end
  end

  assign address      = r_address;
  assign writeData    = r_write_data;
  assign respLoadData = r_load_data;
  assign respError    = r_error;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic        reqRead = 1'b0;
  logic        reqWrite = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] reqAddress = '0;
  logic [31:0] reqWriteData = '0;
  logic        respValid;
  logic [31:0] respLoadData;
  logic        respError;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;

  always #5 clk = ~clk;

  load_store_unit #(.DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqReady(reqReady),
    .reqRead(reqRead), .reqWrite(reqWrite), .funct3(funct3),
    .reqAddress(reqAddress), .reqWriteData(reqWriteData),
    .respValid(respValid), .respLoadData(respLoadData), .respError(respError),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .address(address), .writeData(writeData), .readData(readData)
  );

  // Memory model
  logic [31:0] mem [0:31];
  logic        mem_init = 1'b1;

  assign readData = (address < 32) ? mem[address[4:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int unsigned i = 0; i < 32; i++) mem[i] <= 32'h0;
      mem[3]  <= 32'h8000_7F80;
      mem[5]  <= 32'h1122_3344;
      mem[6]  <= 32'h5566_7788;
      mem[31] <= 32'hA500_0000;
    end else if (MemWrite && address < 32) begin
      mem[address[4:0]] <= writeData;
    end
  end

  int mw_cnt = 0, rv_cnt = 0, both_cnt = 0;
  always @(negedge clk) begin
    if (MemWrite) mw_cnt++;
    if (respValid) rv_cnt++;
    if (MemRead && MemWrite) both_cnt++;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, exp_data;
    logic        exp_err;
    int          exp_lat, exp_nrd, exp_nwr;
    logic [31:0] exp_waddr, exp_wd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_data, input logic exp_err,
                              input int lat, input int nrd, input int nwr,
                              input logic [31:0] waddr, input logic [31:0] wd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_data = exp_data; v.exp_err = exp_err; v.exp_lat = lat;
    v.exp_nrd = nrd; v.exp_nwr = nwr; v.exp_waddr = waddr; v.exp_wd = wd;
    return v;
  endfunction

  task automatic run_req(input int idx, input vec_t v);
    int          lat, nrd, nwr;
    logic        got;
    logic [31:0] seen_addr, seen_wd, data;
    logic        err;
    @(negedge clk);
    chk($sformatf("v%0d ready", idx), {31'h0, reqReady}, 32'h1);
    reqValid = 1'b1; reqRead = v.rd; reqWrite = v.wr; funct3 = v.f3;
    reqAddress = v.addr; reqWriteData = v.wdata;
    @(posedge clk);
    lat = 0; nrd = 0; nwr = 0; got = 1'b0;
    seen_addr = 'x; seen_wd = 'x; data = 'x; err = 1'bx;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (k == 0) reqValid = 1'b0;
      lat++;
      if (MemRead) begin nrd++; seen_addr = address; end
      if (MemWrite) begin nwr++; seen_addr = address; seen_wd = writeData; end
      if (respValid) begin got = 1'b1; data = respLoadData; err = respError; end
    end
    chk($sformatf("v%0d resp_seen", idx), {31'h0, got}, 32'h1);
    chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d error", idx), {31'h0, err}, {31'h0, v.exp_err});
    if (!v.exp_err) chk($sformatf("v%0d data", idx), data, v.exp_data);
    chk($sformatf("v%0d nread", idx), nrd, v.exp_nrd);
    chk($sformatf("v%0d nwrite", idx), nwr, v.exp_nwr);
    if (v.exp_nrd + v.exp_nwr > 0) chk($sformatf("v%0d mem_addr", idx), seen_addr, v.exp_waddr);
    if (v.exp_nwr > 0) chk($sformatf("v%0d write_data", idx), seen_wd, v.exp_wd);
    @(negedge clk);
    chk($sformatf("v%0d resp_one_cycle", idx), {31'h0, respValid}, 32'h0);
    chk($sformatf("v%0d ready_after", idx), {31'h0, reqReady}, 32'h1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " reqReady"}, {31'h0, reqReady}, 32'h1);
    chk({tag, " respValid"}, {31'h0, respValid}, 32'h0);
    chk({tag, " respLoadData"}, respLoadData, 32'h0);
    chk({tag, " respError"}, {31'h0, respError}, 32'h0);
    chk({tag, " MemRead"}, {31'h0, MemRead}, 32'h0);
    chk({tag, " MemWrite"}, {31'h0, MemWrite}, 32'h0);
    chk({tag, " address"}, address, 32'h0);
    chk({tag, " writeData"}, writeData, 32'h0);
  endtask

  initial begin
    int          mw0, rv0;
    logic [7:0]  exp_rdy, exp_rv, exp_mw;

    //        rd wr f3     addr          wdata         exp_data      err lat nr nw waddr wd
    vecs.push_back(mk(1, 0, 3'b000, 32'h0C, 32'h0,         32'hFFFF_FF80, 0, 2, 1, 0, 3,  0));
    vecs.push_back(mk(1, 0, 3'b100, 32'h0D, 32'h0,         32'h0000_007F, 0, 2, 1, 0, 3,  0));
    vecs.push_back(mk(1, 0, 3'b001, 32'h0E, 32'h0,         32'hFFFF_8000, 0, 2, 1, 0, 3,  0));
    vecs.push_back(mk(1, 0, 3'b101, 32'h0E, 32'h0,         32'h0000_8000, 0, 2, 1, 0, 3,  0));
    vecs.push_back(mk(1, 0, 3'b010, 32'h0C, 32'h0,         32'h8000_7F80, 0, 2, 1, 0, 3,  0));
    vecs.push_back(mk(0, 1, 3'b000, 32'h16, 32'hFFFF_FFAB, 32'h0,         0, 3, 1, 1, 5,  32'h11AB_3344));
    vecs.push_back(mk(1, 0, 3'b010, 32'h14, 32'h0,         32'h11AB_3344, 0, 2, 1, 0, 5,  0));
    vecs.push_back(mk(0, 1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0,         0, 2, 0, 1, 4,  32'hDEAD_BEEF));
    vecs.push_back(mk(1, 0, 3'b010, 32'h10, 32'h0,         32'hDEAD_BEEF, 0, 2, 1, 0, 4,  0));
    vecs.push_back(mk(0, 1, 3'b001, 32'h1A, 32'hFFFF_1234, 32'h0,         0, 3, 1, 1, 6,  32'h1234_7788));
    vecs.push_back(mk(1, 0, 3'b001, 32'h18, 32'h0,         32'h0000_7788, 0, 2, 1, 0, 6,  0));
    vecs.push_back(mk(1, 0, 3'b100, 32'h7F, 32'h0,         32'h0000_00A5, 0, 2, 1, 0, 31, 0));
    vecs.push_back(mk(1, 0, 3'b001, 32'h7E, 32'h0,         32'hFFFF_A500, 0, 2, 1, 0, 31, 0));
    // error cases: no memory access, response one cycle after accept
    vecs.push_back(mk(1, 0, 3'b010, 32'h02, 32'h0,         32'h0,         1, 1, 0, 0, 0,  0));
    vecs.push_back(mk(0, 1, 3'b001, 32'h01, 32'h0,         32'h0,         1, 1, 0, 0, 0,  0));
    vecs.push_back(mk(1, 0, 3'b000, 32'h80, 32'h0,         32'h0,         1, 1, 0, 0, 0,  0));
    vecs.push_back(mk(0, 1, 3'b100, 32'h14, 32'h55,        32'h0,         1, 1, 0, 0, 0,  0));
    vecs.push_back(mk(1, 1, 3'b010, 32'h00, 32'h0,         32'h0,         1, 1, 0, 0, 0,  0));
    vecs.push_back(mk(0, 0, 3'b010, 32'h00, 32'h0,         32'h0,         1, 1, 0, 0, 0,  0));
    vecs.push_back(mk(1, 0, 3'b011, 32'h00, 32'h0,         32'h0,         1, 1, 0, 0, 0,  0));

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    mem_init = 1'b0;
    rst_n = 1'b1;

    foreach (vecs[i]) run_req(i, vecs[i]);

    // Back-pressure: SB held continuously; accepted only in IDLE
    exp_rdy = 8'b1000_1000;  // bit k = sample k
    exp_rv  = 8'b0100_0100;
    exp_mw  = 8'b0010_0010;
    @(negedge clk);
    reqValid = 1'b1; reqRead = 1'b0; reqWrite = 1'b1; funct3 = 3'b000;
    reqAddress = 32'h16; reqWriteData = 32'hAB;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d reqReady", k), {31'h0, reqReady}, {31'h0, exp_rdy[k]});
      chk($sformatf("bp%0d respValid", k), {31'h0, respValid}, {31'h0, exp_rv[k]});
      chk($sformatf("bp%0d MemWrite", k), {31'h0, MemWrite}, {31'h0, exp_mw[k]});
    end
    reqValid = 1'b0;
    repeat (2) @(negedge clk);
    chk("bp mem5", mem[5], 32'h11AB_3344);

    // Reset in the READ cycle of an SB
    mw0 = mw_cnt; rv0 = rv_cnt;
    reqValid = 1'b1; reqRead = 1'b0; reqWrite = 1'b1; funct3 = 3'b000;
    reqAddress = 32'h19; reqWriteData = 32'hEE;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    chk("rst_mid MemRead", {31'h0, MemRead}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_mid no MemWrite", mw_cnt - mw0, 0);
    chk("rst_mid no respValid", rv_cnt - rv0, 0);
    chk("rst_mid mem6", mem[6], 32'h1234_7788);
    chk("never both strobes", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the EX stage and the single-ported word-addressed data memory. It converts byte-addressed RISC-V loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses.
- Sub-word stores use read-modify-write; loads are sign- or zero-extended.
- Misaligned and out-of-range accesses are trapped with no memory access.
- A valid/ready request and one-cycle response pulse let the pipeline stall on multi-cycle accesses.

Parameters:
- DEPTH, 32, number of 32-bit words in data memory; legal word index is 0..DEPTH-1.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- reqValid  in  1  request present
- reqReady  out  1  unit can accept a request; high only in IDLE
- reqRead  in  1  load request
- reqWrite  in  1  store request
- funct3  in  3  RISC-V width/sign code
- reqAddress  in  32  byte address
- reqWriteData  in  32  store data, right-aligned
- respValid  out  1  one-cycle completion pulse
- respLoadData  out  32  extended load result, valid with respValid
- respError  out  1  misaligned or out-of-range, valid with respValid
- MemRead  out  1  to data memory
- MemWrite  out  1  to data memory
- address  out  32  word index to data memory: {2'b0, reqAddress[31:2]}
- writeData  out  32  merged word to data memory
- readData  in  32  from data memory, combinational

Behaviour:
- Reset values (asynchronous, rst_n low): state=IDLE; reqReady=1; respValid=0; respLoadData=0; respError=0; MemRead=0; MemWrite=0; address=0; writeData=0. All internal latches are cleared.
- Reset mid-operation aborts the access immediately. No further MemWrite is issued and no response is produced.
- Accept condition: state IDLE and reqValid=1. The unit latches reqRead, reqWrite, funct3, reqAddress and reqWriteData.
- If reqRead and reqWrite are both 1, or both are 0, the request is illegal. It goes to RESP with respError=1.
- funct3 decoding:
  - 000 = byte, signed
  - 001 = half, signed
  - 010 = word
  - 100 = byte, unsigned (loads only)
  - 101 = half, unsigned (loads only)
  - Any other code, including 100 or 101 on a store, sets respError=1.
- Error checks:
  - Misaligned: a half access with address[0]=1, or a word access with address[1:0]≠0.
  - Out of range: address[31:2] ≥ DEPTH.
  - Any error goes directly to RESP with respError=1. No MemRead or MemWrite is asserted.
- States:
  - IDLE: the state at rest and after reset.
  - READ: MemRead=1, MemWrite=0. readData is captured at the end of the cycle.
  - WRITE: MemWrite=1, MemRead=0, writeData = merged word.
  - RESP: respValid=1 for exactly one cycle, then return to IDLE.
- MemRead and MemWrite are never high in the same cycle. They are low in IDLE and RESP.
- Transitions:
  - load: IDLE → READ → RESP
  - SW: IDLE → WRITE → RESP
  - SB/SH: IDLE → READ → WRITE → RESP
  - error: IDLE → RESP
- Latency from the accept edge to the respValid cycle:
  - load: 2 cycles
  - SW: 2 cycles
  - SB/SH: 3 cycles
  - error: 1 cycle
- Byte lane selection: lane = address[1:0], with lane 0 = bits 7:0. The half lane is address[1]; half 0 = bits 15:0.
- Load extension: the selected byte or half is sign-extended (000/001) or zero-extended (100/101). LW passes the word through unchanged.
- Store merge: the captured readData has the selected lane replaced by reqWriteData[7:0] or reqWriteData[15:0]. The other lanes are unchanged.
- During stores, respLoadData holds 0.
- reqReady is 0 outside IDLE. Requests presented in those cycles are ignored, not queued.
- A new request may be accepted in the cycle after RESP, i.e. back to back with one idle cycle of reqReady.
- address and writeData hold their last driven values when inactive.

Test Plan:
1. Memory word 3 = 0x8000_7F80. Issue LB at 0x0C. Required: respValid exactly 2 cycles after accept; respLoadData = 0xFFFF_FF80; respError = 0.
2. Same memory word. LBU at 0x0D → 0x0000_007F. LH at 0x0E → 0xFFFF_8000. LHU at 0x0E → 0x0000_8000.
3. Word 5 = 0x1122_3344. Issue SB at 0x16 with data 0xAB. Required: one READ cycle, then one WRITE cycle with writeData = 0x11AB_3344; respValid 3 cycles after accept; word 5 then reads 0x11AB_3344.
4. Issue SW at 0x10 with data 0xDEAD_BEEF. Required: MemRead is never high; MemWrite is high for exactly 1 cycle with address = 4; respValid 2 cycles after accept.
5. Error cases:
   - LW at 0x02, SH at 0x01, LB at 0x80 (word index 32 with DEPTH=32), and SB with funct3=100.
   - Required for each: respError = 1 one cycle after accept, with MemRead and MemWrite held at 0.
6. Reset and back-pressure:
   - Pull rst_n low in the READ cycle of an SB. Required: MemWrite never rises, outputs reach their reset values immediately, no respValid, and memory is unchanged.
   - Hold reqValid high continuously. Required: reqReady is low during READ, WRITE and RESP, and each request is accepted only in IDLE.
